// File: rtl/song_sequencer.sv
// song_sequencer: walks one song in a synchronous song ROM and issues one
// note load per entry. The note lasts for the entry's duration in beats.
// Ports:
//   clk, reset (async, active high), play (run/pause level),
//   song_select (read only when a song starts), beat (one-cycle tick),
//   rom_addr = {song, idx}, rom_data (valid one cycle after rom_addr),
//   note_to_load / weight (held until the next load), load_new_note,
//   note_done, song_done (one-cycle pulses), note_play_enable, busy.
module song_sequencer #(
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5,
    parameter int DUR_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song_select,
    input  logic                    beat,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [15:0]             rom_data,
    output logic [5:0]              note_to_load,
    output logic [1:0]              weight,
    output logic                    load_new_note,
    output logic                    note_done,
    output logic                    note_play_enable,
    output logic                    song_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_NOTE_END,
        S_ADVANCE,
        S_SONG_END
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [SONG_W-1:0]  r_song;
    logic [IDX_W-1:0]   r_idx;
    logic [DUR_W-1:0]   r_cnt;
    logic [5:0]         r_note;
    logic [1:0]         r_weight;
    logic               r_load;
    logic               r_armed;

    logic               w_eos;
    logic [1:0]         w_weight;
    logic [5:0]         w_note;
    logic [DUR_W-1:0]   w_dur;
    logic               w_tick;
    logic               w_unused_bit;

    assign w_eos        = rom_data[15];
    assign w_weight     = rom_data[14:13];
    assign w_note       = rom_data[12:7];
    assign w_dur        = rom_data[DUR_W:1];
    assign w_unused_bit = rom_data[0];

    // A beat only counts while play is high; otherwise the note is paused.
    assign w_tick = beat && play;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (play && r_armed) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_eos) begin
                    w_next = S_SONG_END;
                end else if (w_dur == '0) begin
                    w_next = S_ADVANCE;
                end else begin
                    w_next = S_PLAY;
                end
            end
            S_PLAY: begin
                // The counter is never zero here: zero-length entries skip PLAY.
                if (w_tick && (r_cnt == DUR_W'(1))) begin
                    w_next = S_NOTE_END;
                end
            end
            S_NOTE_END: begin
                w_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (r_idx == '1) begin
                    w_next = S_SONG_END;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_SONG_END: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_song   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_note   <= '0;
            r_weight <= '0;
            r_load   <= 1'b0;
            r_armed  <= 1'b1;
        end else begin
            r_load <= (r_state == S_DECODE) && (w_next == S_PLAY);

            // Disarm when a song finishes so a held play does not replay it;
            // any cycle with play low re-arms.
            if ((w_next == S_SONG_END) && (r_state != S_SONG_END)) begin
                r_armed <= 1'b0;
            end else if (!play) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_next == S_FETCH) begin
                        r_song <= song_select;
                        r_idx  <= '0;
                    end
                end
                S_DECODE: begin
                    if (w_next == S_PLAY) begin
                        r_note   <= w_note;
                        r_weight <= w_weight;
                        r_cnt    <= w_dur;
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        r_cnt <= r_cnt - DUR_W'(1);
                    end
                end
                S_ADVANCE: begin
                    if (w_next == S_FETCH) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_SONG_END: begin
                    r_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr         = {r_song, r_idx};
    assign note_to_load     = r_note;
    assign weight           = r_weight;
    assign load_new_note    = r_load;
    assign note_done        = (r_state == S_NOTE_END);
    assign song_done        = (r_state == S_SONG_END);
    assign busy             = (r_state != S_IDLE);
    assign note_play_enable = play && busy;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a behavioural ROM plus an event
// schedule built from the sequencing rules, compared every cycle.
module tb_song_sequencer;

    localparam int MAXC = 1500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        beat = 1'b0;
    logic [1:0]  song_select = 2'd0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic [5:0]  note_to_load;
    logic [1:0]  weight;
    logic        load_new_note;
    logic        note_done;
    logic        note_play_enable;
    logic        song_done;
    logic        busy;

    song_sequencer #(.SONG_W(2), .IDX_W(5), .DUR_W(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song_select      (song_select),
        .beat             (beat),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .weight           (weight),
        .load_new_note    (load_new_note),
        .note_done        (note_done),
        .note_play_enable (note_play_enable),
        .song_done        (song_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [128];

    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors = 0;
    int checks = 0;
    int cur_c  = 0;

    bit pl [MAXC];
    bit bt [MAXC];
    bit e_ld [MAXC];
    bit e_nd [MAXC];
    int e_addr [MAXC];
    int e_note [MAXC];
    int e_w [MAXC];
    int sd_cyc;
    int hold_note = 0;
    int hold_w = 0;
    bit aborted;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h",
                   tag, cur_c, obs, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_addr"}, 16'(rom_addr), 16'd0);
        chk({tag, "_note"}, 16'(note_to_load), 16'd0);
        chk({tag, "_w"}, 16'(weight), 16'd0);
        chk({tag, "_ld"}, 16'(load_new_note), 16'd0);
        chk({tag, "_nd"}, 16'(note_done), 16'd0);
        chk({tag, "_sd"}, 16'(song_done), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_npe"}, 16'(note_play_enable), 16'd0);
    endtask

    function automatic logic [15:0] ent(int eos, int w, int n, int d);
        logic [31:0] e, wv, nv, dv;
        e  = eos;
        wv = w;
        nv = n;
        dv = d;
        return {e[0], wv[1:0], nv[5:0], dv[5:0], 1'b0};
    endfunction

    // period > 0: beat on every period-th cycle; else random beats.
    // rnd_play: random pauses; [pa, pb): forced pause window.
    task automatic gen(int period, bit rnd_play, int pa, int pb);
        for (int k = 0; k < MAXC; k++) begin
            if (period > 0) bt[k] = ((k % period) == period - 1);
            else bt[k] = ($urandom_range(0, 2) == 0);
            pl[k] = rnd_play ? ($urandom_range(0, 4) != 0) : 1'b1;
            if (k >= pa && k < pb) pl[k] = 1'b0;
        end
        pl[0] = 1'b1;
    endtask

    // Expected events with the song started at cycle 0:
    // an entry's first possible play cycle p is 3 after start, 4 after
    // the previous note_done, or 3 after the ADVANCE of a skipped entry.
    task automatic sched(int song);
        int p, idx, c, cnt, d, cn, cw;
        logic [15:0] w;
        for (int k = 0; k < MAXC; k++) begin
            e_ld[k] = 1'b0;
            e_nd[k] = 1'b0;
            e_addr[k] = -1;
        end
        p = 3;
        idx = 0;
        sd_cyc = -1;
        while (sd_cyc < 0 && p < MAXC - 20) begin
            w = rom[7'(song * 32 + idx)];
            d = int'(w[6:1]);
            if (w[15]) begin
                sd_cyc = p;
            end else if (d == 0) begin
                if (idx == 31) sd_cyc = p + 1;
                else begin
                    p += 3;
                    idx++;
                end
            end else begin
                e_ld[p] = 1'b1;
                e_addr[p] = song * 32 + idx;
                e_note[p] = int'(w[12:7]);
                e_w[p] = int'(w[14:13]);
                cnt = 0;
                c = p;
                while (c < MAXC - 10) begin
                    if (pl[c] && bt[c]) cnt++;
                    if (cnt == d) break;
                    c++;
                end
                e_nd[c + 1] = 1'b1;
                if (idx == 31) sd_cyc = c + 3;
                else begin
                    p = c + 5;
                    idx++;
                end
            end
        end
        cn = hold_note;
        cw = hold_w;
        for (int k = 0; k < MAXC; k++) begin
            if (e_ld[k]) begin
                cn = e_note[k];
                cw = e_w[k];
            end else begin
                e_note[k] = cn;
                e_w[k] = cw;
            end
        end
        if (sd_cyc >= 1)
            for (int k = sd_cyc - 1; k < MAXC; k++) pl[k] = 1'b1;
    endtask

    task automatic run(int song, bit prearm, int abort);
        int n;
        bit eb;
        logic [6:0] home;
        aborted = 1'b0;
        sched(song);
        n = (sd_cyc < 0) ? MAXC - 10 : sd_cyc + 9;
        home = 7'(song * 32);
        if (prearm) begin
            @(posedge clk);
            #1;
            play = 1'b0;
            beat = 1'b0;
            song_select = 2'(song);
        end
        for (int c = 0; c < n; c++) begin
            if (c > 0 || prearm) begin
                @(posedge clk);
                #1;
            end
            cur_c = c;
            play = pl[c];
            beat = bt[c];
            song_select = (c == 0) ? 2'(song) : 2'($urandom);
            @(negedge clk);
            eb = (c >= 1) && (sd_cyc < 0 || c <= sd_cyc);
            chk("load", 16'(load_new_note), 16'(e_ld[c]));
            chk("note_done", 16'(note_done), 16'(e_nd[c]));
            chk("song_done", 16'(song_done), 16'(c == sd_cyc));
            chk("busy", 16'(busy), 16'(eb));
            chk("npe", 16'(note_play_enable), 16'(pl[c] && eb));
            chk("note", 16'(note_to_load), 16'(e_note[c]));
            chk("weight", 16'(weight), 16'(e_w[c]));
            if (e_addr[c] >= 0)
                chk("addr_load", 16'(rom_addr), 16'(e_addr[c]));
            if (sd_cyc >= 0 && c > sd_cyc)
                chk("addr_home", 16'(rom_addr), 16'(home));
            if (c == abort) begin
                #2 reset = 1'b1;
                #1 chk_zero("async_reset");
                aborted = 1'b1;
                return;
            end
        end
        hold_note = e_note[n - 1];
        hold_w = e_w[n - 1];
    endtask

    initial begin
        for (int k = 0; k < 128; k++) rom[k] = 16'd0;
        // song 0: 32 entries, no end flag
        for (int k = 0; k < 32; k++)
            rom[k] = ent(0, $urandom_range(0, 3), $urandom_range(1, 63),
                         $urandom_range(1, 2));
        // song 1: basic two-note song
        rom[32] = ent(0, 2, 20, 3);
        rom[33] = ent(0, 0, 33, 1);
        rom[34] = ent(1, 0, 0, 0);
        // song 2: long note for pause and reset cases
        rom[64] = ent(0, 1, 17, 4);
        rom[65] = ent(0, 3, 40, 2);
        rom[66] = ent(1, 0, 0, 0);
        // song 3: zero-duration entry between two notes
        rom[96] = ent(0, 1, 5, 2);
        rom[97] = ent(0, 2, 7, 0);
        rom[98] = ent(0, 3, 9, 1);
        rom[99] = ent(1, 0, 0, 0);

        @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk);
        #1 reset = 1'b0;

        gen(10, 1'b0, 0, 0);
        run(1, 1'b1, -1);

        gen(4, 1'b0, 5, 25);
        run(2, 1'b1, -1);

        gen(0, 1'b1, 0, 0);
        run(3, 1'b1, -1);

        gen(0, 1'b1, 0, 0);
        run(0, 1'b1, -1);

        gen(0, 1'b1, 0, 0);
        run(2, 1'b1, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        hold_note = 0;
        hold_w = 0;
        gen(0, 1'b1, 0, 0);
        run(1, 1'b0, -1);

        gen(0, 1'b1, 0, 0);
        run(2, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Drives the note-player side of the music pipeline: walks a song stored in an external synchronous song ROM, one entry at a time.
- For each entry it issues one note load (note, weight), counts the note's duration in beats, then signals the note's end.
- Sits between the top-level play/song-select controls and the note player.
- Pauses beat counting while play is low; reports completion when the song ends.

Parameters:
- SONG_W, 2, width of song_select; number of songs = 2^SONG_W.
- IDX_W, 5, note-index width; entries per song = 2^IDX_W.
- DUR_W, 6, duration field width, in beats.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- play  in  1  level; high = run/resume, low = pause.
- song_select  in  SONG_W  song to play; sampled only at song start.
- beat  in  1  one-cycle tick per beat.
- rom_addr  out  SONG_W+IDX_W  {song_latched, note_idx}.
- rom_data  in  16  ROM word, valid one cycle after rom_addr.
  - [15] end_of_song
  - [14:13] weight
  - [12:7] note
  - [6:1] duration
  - [0] ignored
- note_to_load  out  6  current note; 0 = rest.
- weight  out  2  harmonic weight for the current note.
- load_new_note  out  1  one-cycle pulse.
- note_done  out  1  one-cycle pulse.
- note_play_enable  out  1  play AND (state is not IDLE).
- song_done  out  1  one-cycle pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - note_idx = 0, beat counter = 0, armed = 1.
  - Reset is asynchronous and takes effect mid-operation, from any state.
- armed: set whenever play = 0; cleared on entry to SONG_END. This prevents auto-replay while play is held high.
- IDLE:
  - If play && armed, latch song_select, set note_idx = 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: rom_addr presents {song, idx}; go to DECODE next cycle.
- DECODE (rom_data valid):
  - end_of_song = 1 -> SONG_END.
  - Else duration = 0 -> ADVANCE; no load_new_note, no note_done.
  - Else:
    - Register note_to_load and weight.
    - Load the counter with duration.
    - Pulse load_new_note.
    - Go to PLAY.
    - load_new_note and the new note_to_load are visible in the first PLAY cycle.
- PLAY:
  - Each cycle with beat && play, decrement the counter.
  - The decrement that reaches 0 moves to NOTE_END.
  - Beats with play = 0 are ignored (pause); the counter is held.
  - A beat coincident with the first PLAY cycle counts.
- NOTE_END: note_done = 1 for this single cycle; then ADVANCE.
- ADVANCE:
  - If note_idx = 2^IDX_W - 1, go to SONG_END (implicit end).
  - Else note_idx += 1 and go to FETCH.
- SONG_END: song_done = 1 for one cycle; note_idx = 0; go to IDLE.
- Latency:
  - play rising in IDLE at cycle 0 -> FETCH at cycle 1 -> DECODE at cycle 2 -> load_new_note at cycle 3.
  - Note with duration d and no pause: note_done comes 1 cycle after the d-th counted beat.
  - Next load_new_note follows note_done by 4 cycles (ADVANCE, FETCH, DECODE, PLAY).
- Output holding:
  - note_to_load and weight hold their value until the next load.
  - They are not cleared at note_done or song end.
- song_select changes after start are ignored until the next start.
- play dropping in FETCH, DECODE, ADVANCE or NOTE_END does not stall those states; only beat counting pauses.
- Pulses: load_new_note, note_done and song_done are never high in the same cycle, and each is never longer than one cycle.

Test Plan:
- Reset, then play = 1 with song_select = 1, ROM song 1 = {note 20, dur 3, w 2}, {note 33, dur 1, w 0}, {end}, beat every 10 cycles:
  - rom_addr = 0x20 in FETCH.
  - load_new_note at cycle 3 with note_to_load = 20, weight = 2.
  - note_done one cycle after the 3rd beat.
  - Second load has note 33.
  - song_done once; busy falls.
- Pause: during a dur 4 note, hold play = 0 across 5 beats:
  - Counter is frozen.
  - note_done arrives only after 4 beats counted with play = 1.
  - note_play_enable tracks play.
- Duration-0 entry between two notes: no load or done pulse for it; the next note loads 3 cycles after ADVANCE.
- Song with 32 entries and no end flag: after idx 31's note_done, song_done fires and rom_addr returns to {song, 0}.
- After song_done with play held high: stays IDLE, no FETCH. Drop play for 1 cycle and raise it again: restarts at idx 0.
- Assert reset in PLAY mid-note:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with play = 1, sequencing restarts from idx 0 of the current song_select.
